// File: rtl/truth_table_sweeper.sv
// Sweeps all eight input rows of a 3-input gate, samples its output after a
// programmable settle time and compares the measured truth table to EXPECTED.
module truth_table_sweeper #(
  parameter logic [7:0]  EXPECTED = 8'hAE,
  parameter int unsigned SETTLE   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] measured,
  output logic [7:0] mismatch,
  output logic       pass
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, FINISH} state_t;

  localparam logic [7:0] RELOAD = 8'(SETTLE - 1);

  state_t     state;
  logic [2:0] row;
  logic [7:0] cnt;

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of one another, whatever order the statements appear in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      row             <= '0;
      cnt             <= '0;
      {in1, in2, in3} <= 3'b000;
      busy            <= 1'b0;
      done            <= 1'b0;
      measured        <= '0;
      mismatch        <= '0;
      pass            <= 1'b0;
    end else if (abort && (state == APPLY || state == SAMPLE)) begin
      // Abort beats a same-cycle capture; rows already captured are kept.
      state           <= IDLE;
      row             <= '0;
      cnt             <= '0;
      {in1, in2, in3} <= 3'b000;
      busy            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state           <= APPLY;
            row             <= '0;
            cnt             <= RELOAD;
            {in1, in2, in3} <= 3'b000;
            busy            <= 1'b1;
            measured        <= '0;
            mismatch        <= '0;
            pass            <= 1'b0;
          end
        end

        APPLY: begin
          if (cnt == '0) state <= SAMPLE;
          else           cnt   <= cnt - 8'd1;
        end

        SAMPLE: begin
          measured[3'd7 - row] <= dut_out;
          if (row == 3'd7) begin
            state           <= FINISH;
            done            <= 1'b1;
            {in1, in2, in3} <= 3'b000;
          end else begin
            state           <= APPLY;
            row             <= row + 3'd1;
            cnt             <= RELOAD;
            {in1, in2, in3} <= row + 3'd1;
          end
        end

        FINISH: begin
          done     <= 1'b0;
          mismatch <= measured ^ EXPECTED;
          pass     <= (measured == EXPECTED);
          // A start seen on the edge ending done chains straight into the next
          // sweep; the just-computed verdict stays visible while it runs.
          if (start && !abort) begin
            state           <= APPLY;
            row             <= '0;
            cnt             <= RELOAD;
            {in1, in2, in3} <= 3'b000;
            measured        <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: unit 0 (SETTLE=4) and unit 1 (SETTLE=1) are
// checked every cycle against a timeline model, plus literal expectations.
module tb_truth_table_sweeper;

  localparam logic [7:0] EXP_TT = 8'hAE;
  localparam int SET0 = 4;
  localparam int SET1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       start_v [2];
  logic       abort_v [2];
  logic       dout_v  [2];
  logic       in1_v   [2];
  logic       in2_v   [2];
  logic       in3_v   [2];
  logic       busy_v  [2];
  logic       done_v  [2];
  logic [7:0] meas_v  [2];
  logic [7:0] mis_v   [2];
  logic       pass_v  [2];

  int mode = 0;  // gate on unit 0: 0 = correct 0xAE, 1 = stuck at 0, 2 = inverted
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic gate_fn(input int md, input logic [2:0] r);
    logic v;
    v = EXP_TT[3'd7 - r];
    case (md)
      1:       return 1'b0;
      2:       return ~v;
      default: return v;
    endcase
  endfunction

  assign dout_v[0] = gate_fn(mode, {in1_v[0], in2_v[0], in3_v[0]});
  assign dout_v[1] = gate_fn(0,    {in1_v[1], in2_v[1], in3_v[1]});

  truth_table_sweeper #(.EXPECTED(EXP_TT), .SETTLE(SET0)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .dut_out(dout_v[0]),
    .in1(in1_v[0]), .in2(in2_v[0]), .in3(in3_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .measured(meas_v[0]), .mismatch(mis_v[0]), .pass(pass_v[0])
  );

  truth_table_sweeper #(.EXPECTED(EXP_TT), .SETTLE(SET1)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .dut_out(dout_v[1]),
    .in1(in1_v[1]), .in2(in2_v[1]), .in3(in3_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .measured(meas_v[1]), .mismatch(mis_v[1]), .pass(pass_v[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: t counts edges since the start-sampling edge; each row
  // spans p = SETTLE+1 edges, captures land on multiples of p, t == 8p is the done cycle.
  int         m_t    [2];
  bit         m_act  [2];
  logic [7:0] m_meas [2];
  logic [7:0] m_mis  [2];
  bit         m_pass [2];

  function automatic int period(input int i);
    return (i == 0) ? SET0 + 1 : SET1 + 1;
  endfunction

  task automatic model_step();
    int p;
    for (int i = 0; i < 2; i++) begin
      p = period(i);
      if (rst) begin
        m_act[i] = 0; m_t[i] = 0; m_meas[i] = '0; m_mis[i] = '0; m_pass[i] = 0;
      end else if (!m_act[i]) begin
        if (start_v[i] && !abort_v[i]) begin
          m_act[i] = 1; m_t[i] = 0; m_meas[i] = '0; m_mis[i] = '0; m_pass[i] = 0;
        end
      end else if (m_t[i] == 8 * p) begin
        m_mis[i]  = m_meas[i] ^ EXP_TT;
        m_pass[i] = (m_meas[i] == EXP_TT);
        if (start_v[i] && !abort_v[i]) begin
          m_t[i] = 0; m_meas[i] = '0;
        end else begin
          m_act[i] = 0;
        end
      end else if (abort_v[i]) begin
        m_act[i] = 0;
      end else begin
        m_t[i]++;
        if (m_t[i] % p == 0)
          m_meas[i][8 - m_t[i] / p] = gate_fn((i == 0) ? mode : 0, 3'(m_t[i] / p - 1));
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    int p;
    logic [2:0] e_row;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      p = period(i);
      e_row = (m_act[i] && m_t[i] < 8 * p) ? 3'(m_t[i] / p) : 3'd0;
      check($sformatf("u%0d_row", i), {in1_v[i], in2_v[i], in3_v[i]}, e_row);
      check($sformatf("u%0d_busy", i), busy_v[i], m_act[i]);
      check($sformatf("u%0d_done", i), done_v[i], m_act[i] && m_t[i] == 8 * p);
      check($sformatf("u%0d_measured", i), meas_v[i], m_meas[i]);
      check($sformatf("u%0d_mismatch", i), mis_v[i], m_mis[i]);
      check($sformatf("u%0d_pass", i), pass_v[i], m_pass[i]);
    end
  end

  // Returns at the negedge of cycle 0 (start sampled on the edge just before).
  task automatic pulse_start(input int i);
    @(negedge clk); start_v[i] = 1'b1;
    @(negedge clk); start_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int limit, output int c);
    c = 0;
    while (done_v[i] !== 1'b1 && c < limit) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] m, input logic [7:0] x,
                              input logic ps);
    check({tag, "_measured"}, meas_v[0], m);
    check({tag, "_mismatch"}, mis_v[0], x);
    check({tag, "_pass"}, pass_v[0], ps);
    check({tag, "_busy"}, busy_v[0], 1'b0);
  endtask

  initial begin
    int c;
    int n;
    for (int i = 0; i < 2; i++) begin start_v[i] = 1'b0; abort_v[i] = 1'b0; end

    repeat (2) @(negedge clk);
    check("reset_busy", busy_v[0], 1'b0);
    check("reset_measured", meas_v[0], 8'h00);
    check("reset_row", {in1_v[0], in2_v[0], in3_v[0]}, 3'b000);
    #2 rst = 1'b0;

    // Correct gate: done in cycle 40, results valid in cycle 41.
    pulse_start(0);
    wait_done(0, 100, c);
    check("good_done_cycle", c, 40);
    @(negedge clk);
    check_result("good", 8'hAE, 8'h00, 1'b1);

    mode = 1;
    pulse_start(0);
    wait_done(0, 100, c);
    @(negedge clk);
    check_result("stuck0", 8'h00, 8'hAE, 1'b0);

    mode = 2;
    pulse_start(0);
    wait_done(0, 100, c);
    @(negedge clk);
    check_result("invert", 8'h51, 8'hFF, 1'b0);

    // start with abort in IDLE is ignored
    mode = 0;
    @(negedge clk); start_v[0] = 1'b1; abort_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0; abort_v[0] = 1'b0;
    check("start_abort_busy", busy_v[0], 1'b0);

    // start re-pulsed at cycles 3 and 20 does not restart the sweep
    pulse_start(0);
    repeat (3) @(negedge clk);
    start_v[0] = 1'b1; @(negedge clk); start_v[0] = 1'b0;
    repeat (16) @(negedge clk);
    start_v[0] = 1'b1; @(negedge clk); start_v[0] = 1'b0;
    wait_done(0, 100, c);
    check("repulse_done_cycle", c + 21, 40);
    @(negedge clk);
    check_result("repulse", 8'hAE, 8'h00, 1'b1);

    // abort in row 3 APPLY (cycle 16, taken on edge 17)
    pulse_start(0);
    repeat (16) @(negedge clk);
    abort_v[0] = 1'b1; @(negedge clk); abort_v[0] = 1'b0;
    check_result("abort", 8'hA0, 8'h00, 1'b0);
    n = 0;
    repeat (50) begin @(negedge clk); if (done_v[0] === 1'b1) n++; end
    check("abort_no_done", n, 0);

    // reset during row 5
    pulse_start(0);
    repeat (27) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", busy_v[0], 1'b0);
    check("rst_measured", meas_v[0], 8'h00);
    check("rst_row", {in1_v[0], in2_v[0], in3_v[0]}, 3'b000);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    pulse_start(0);
    wait_done(0, 100, c);
    check("post_rst_done_cycle", c, 40);
    @(negedge clk);
    check_result("post_rst", 8'hAE, 8'h00, 1'b1);

    // SETTLE=1, start held high: done at 16, 33, 50, 67
    @(negedge clk); start_v[1] = 1'b1;
    @(negedge clk);
    n = 0;
    for (int k = 0; k < 72; k++) begin
      if (done_v[1] === 1'b1) n++;
      if (k == 16 || k == 33 || k == 50) check($sformatf("b2b_done_c%0d", k), done_v[1], 1'b1);
      if (k == 15 || k == 32) check($sformatf("b2b_nodone_c%0d", k), done_v[1], 1'b0);
      if (k == 17 || k == 34 || k == 51) check($sformatf("b2b_pass_c%0d", k), pass_v[1], 1'b1);
      if (k == 55) start_v[1] = 1'b0;
      @(negedge clk);
    end
    check("b2b_done_count", n, 4);
    check("b2b_idle_busy", busy_v[1], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
